// File: rtl/fwvip_wb_target_mem.sv
// Wishbone classic-cycle target backed by a byte-enabled word memory.
// Responds with ACK on an in-range aligned access, ERR otherwise, after
// WAIT_STATES extra cycles. All outputs are registered.
module fwvip_wb_target_mem #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            DEPTH_LOG2  = 8,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned            WAIT_STATES = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   adr,
    input  logic [DATA_WIDTH-1:0]   dat_w,
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic                    we,
    input  logic                    cyc,
    input  logic                    stb,
    output logic [DATA_WIDTH-1:0]   dat_r,
    output logic                    ack,
    output logic                    err
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned LB    = $clog2(BYTES);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, hit_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [BYTES-1:0]        sel_q;
    logic [DATA_WIDTH-1:0]   dat_w_q;
    logic                    ack_q, ack_d, err_q, err_d;
    logic [DATA_WIDTH-1:0]   dat_r_q, dat_r_d;
    logic                    take, mem_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Address decode: in range above the base and word aligned.
    logic [ADDR_WIDTH-1:0]   offset;
    logic                    hit;
    logic [DEPTH_LOG2-1:0]   idx;
    assign offset = adr - BASE_ADDR;
    assign hit    = (adr >= BASE_ADDR) &&
                    ((offset >> (DEPTH_LOG2 + LB)) == '0) &&
                    ((adr & ADDR_WIDTH'(BYTES - 1)) == '0);
    assign idx    = offset[LB +: DEPTH_LOG2];

    // Next-state and response generation. The latched request always passes
    // through StWait so the response lands WAIT_STATES+1 edges after sampling.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_r_d = '0;
        take    = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cyc && stb) begin
                    take    = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!cyc) begin
                    // Initiator abandoned the cycle: no response, no write.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    ack_d   = hit_q;
                    err_d   = !hit_q;
                    mem_we  = hit_q && we_q;
                    if (hit_q && !we_q) begin
                        dat_r_d = mem[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            sel_q   <= '0;
            dat_w_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_r_q <= dat_r_d;
            if (take) begin
                we_q    <= we;
                hit_q   <= hit;
                idx_q   <= idx;
                sel_q   <= sel;
                dat_w_q <= dat_w;
            end
        end
    end

    // Byte-lane memory write; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < int'(BYTES); i++) begin
                if (sel_q[i]) begin
                    mem[idx_q][8*i +: 8] <= dat_w_q[8*i +: 8];
                end
            end
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign dat_r = dat_r_q;

endmodule

// File: tb/tb_fwvip_wb_target_mem.sv
// Directed bench: three targets with 0, 3 and 2 wait states.
module tb_fwvip_wb_target_mem;

    logic        clock;
    logic        reset;
    logic [31:0] adr   [3];
    logic [31:0] dat_w [3];
    logic [31:0] dat_r [3];
    logic [3:0]  sel   [3];
    logic        we    [3];
    logic        cyc   [3];
    logic        stb   [3];
    logic        ack   [3];
    logic        err   [3];

    int total = 0;
    int bad   = 0;
    int ack_seen0 = 0;

    fwvip_wb_target_mem #(.WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset(reset), .adr(adr[0]), .dat_w(dat_w[0]), .sel(sel[0]),
        .we(we[0]), .cyc(cyc[0]), .stb(stb[0]), .dat_r(dat_r[0]), .ack(ack[0]), .err(err[0])
    );
    fwvip_wb_target_mem #(.WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset(reset), .adr(adr[1]), .dat_w(dat_w[1]), .sel(sel[1]),
        .we(we[1]), .cyc(cyc[1]), .stb(stb[1]), .dat_r(dat_r[1]), .ack(ack[1]), .err(err[1])
    );
    fwvip_wb_target_mem #(.WAIT_STATES(2)) u_ws2 (
        .clock(clock), .reset(reset), .adr(adr[2]), .dat_w(dat_w[2]), .sel(sel[2]),
        .we(we[2]), .cyc(cyc[2]), .stb(stb[2]), .dat_r(dat_r[2]), .ack(ack[2]), .err(err[2])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One sample per cycle: a one-cycle pulse counts once.
    always @(negedge clock) begin
        if (ack[0]) ack_seen0 <= ack_seen0 + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One transfer; lat = edges from the sampling edge to the response edge.
    task automatic xfer(input int k, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w, output logic [31:0] rd,
                        output int lat, output logic ga, output logic ge, output logic wide);
        adr[k] = a; dat_w[k] = d; sel[k] = s; we[k] = w; cyc[k] = 1'b1; stb[k] = 1'b1;
        lat = -1;
        do begin
            tick();
            lat++;
        end while (!(ack[k] || err[k]) && lat < 40);
        ga = ack[k]; ge = err[k]; rd = dat_r[k];
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        tick();
        wide = ack[k] | err[k];
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            total++; if (ack[k] !== 1'b0) begin bad++; $display("FAIL rst_ack[%0d] got=%b want=0", k, ack[k]); end
            total++; if (err[k] !== 1'b0) begin bad++; $display("FAIL rst_err[%0d] got=%b want=0", k, err[k]); end
            total++; if (dat_r[k] !== 32'h0) begin bad++; $display("FAIL rst_dat_r[%0d] got=%h want=0", k, dat_r[k]); end
        end
    endtask

    task automatic test_write_readback();
        logic [31:0] rd; int lat; logic ga, ge, wide; int start;
        start = ack_seen0;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, v;
            a = 32'h1000_0000 + 32'(4 * (i % 3));
            v = 32'hA5A5_0000 + 32'(i % 3);
            xfer(0, a, v, 4'hF, (i < 3), rd, lat, ga, ge, wide);
            total++; if (ga !== 1'b1) begin bad++; $display("FAIL wrb_ack[%0d] got=%b want=1", i, ga); end
            total++; if (ge !== 1'b0) begin bad++; $display("FAIL wrb_err[%0d] got=%b want=0", i, ge); end
            total++; if (lat !== 1) begin bad++; $display("FAIL wrb_lat[%0d] got=%0d want=1", i, lat); end
            total++; if (wide !== 1'b0) begin bad++; $display("FAIL wrb_width[%0d] got=%b want=0", i, wide); end
            total++; if (rd !== ((i < 3) ? 32'h0 : v)) begin
                bad++; $display("FAIL wrb_data[%0d] got=%h want=%h", i, rd, (i < 3) ? 32'h0 : v);
            end
        end
        total++; if (ack_seen0 - start !== 6) begin bad++; $display("FAIL wrb_ack_count got=%0d want=6", ack_seen0 - start); end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd; int lat; logic ga, ge, wide;
        xfer(0, 32'h1000_0010, 32'h1122_3344, 4'hF, 1'b1, rd, lat, ga, ge, wide);
        xfer(0, 32'h1000_0010, 32'hFFFF_FFFF, 4'b0010, 1'b1, rd, lat, ga, ge, wide);
        total++; if (ga !== 1'b1) begin bad++; $display("FAIL be_ack got=%b want=1", ga); end
        xfer(0, 32'h1000_0010, 32'h0, 4'h0, 1'b0, rd, lat, ga, ge, wide);
        total++; if (rd !== 32'h1122_FF44) begin bad++; $display("FAIL be_data got=%h want=1122ff44", rd); end
        // sel=0 write acks but leaves the word alone; last word is in range.
        xfer(0, 32'h1000_0010, 32'h0, 4'h0, 1'b1, rd, lat, ga, ge, wide);
        total++; if (ga !== 1'b1) begin bad++; $display("FAIL be_sel0_ack got=%b want=1", ga); end
        xfer(0, 32'h1000_03FC, 32'h7777_0001, 4'hF, 1'b1, rd, lat, ga, ge, wide);
        xfer(0, 32'h1000_03FC, 32'h0, 4'hF, 1'b0, rd, lat, ga, ge, wide);
        total++; if (rd !== 32'h7777_0001) begin bad++; $display("FAIL be_last_word got=%h want=77770001", rd); end
        xfer(0, 32'h1000_0010, 32'h0, 4'h0, 1'b0, rd, lat, ga, ge, wide);
        total++; if (rd !== 32'h1122_FF44) begin bad++; $display("FAIL be_sel0_data got=%h want=1122ff44", rd); end
    endtask

    task automatic test_error_decode();
        logic [31:0] rd; int lat; logic ga, ge, wide;
        logic [31:0] ea [4];
        logic        ew [4];
        ea[0] = 32'h0FFF_FFFC; ew[0] = 1'b0;
        ea[1] = 32'h1000_0402; ew[1] = 1'b1;
        ea[2] = 32'h1000_0400; ew[2] = 1'b0;
        ea[3] = 32'h1000_0006; ew[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            xfer(0, ea[i], 32'h5A5A_5A5A, 4'hF, ew[i], rd, lat, ga, ge, wide);
            total++; if (ge !== 1'b1) begin bad++; $display("FAIL err_err[%0d] got=%b want=1", i, ge); end
            total++; if (ga !== 1'b0) begin bad++; $display("FAIL err_ack[%0d] got=%b want=0", i, ga); end
            total++; if (rd !== 32'h0) begin bad++; $display("FAIL err_dat_r[%0d] got=%h want=0", i, rd); end
            total++; if (wide !== 1'b0) begin bad++; $display("FAIL err_width[%0d] got=%b want=0", i, wide); end
        end
        xfer(0, 32'h1000_0004, 32'h0, 4'hF, 1'b0, rd, lat, ga, ge, wide);
        total++; if (rd !== 32'hA5A5_0001) begin bad++; $display("FAIL err_mem_kept got=%h want=a5a50001", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; int lat; logic ga, ge, wide;
        int first, second, hi_run;
        logic prev;
        xfer(1, 32'h1000_0008, 32'h0BAD_F00D, 4'hF, 1'b1, rd, lat, ga, ge, wide);
        total++; if (lat !== 4) begin bad++; $display("FAIL ws_lat got=%0d want=4", lat); end
        total++; if (wide !== 1'b0) begin bad++; $display("FAIL ws_width got=%b want=0", wide); end
        // Hold the request continuously: the next one must not be taken before N+6.
        adr[1] = 32'h1000_0008; we[1] = 1'b0; sel[1] = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
        first = -1; second = -1; hi_run = 0; prev = 1'b0;
        for (int e = 0; e < 14; e++) begin
            tick();
            if (ack[1] && !prev) begin
                if (first < 0) first = e; else if (second < 0) second = e;
            end
            if (ack[1] && prev) hi_run++;
            prev = ack[1];
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        tick(); tick();
        total++; if (first !== 4) begin bad++; $display("FAIL ws_b2b_first got=%0d want=4", first); end
        total++; if (second !== 10) begin bad++; $display("FAIL ws_b2b_second got=%0d want=10", second); end
        total++; if (hi_run !== 0) begin bad++; $display("FAIL ws_b2b_width got=%0d want=0", hi_run); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat; logic ga, ge, wide; int resp;
        xfer(1, 32'h1000_0020, 32'h0000_0001, 4'hF, 1'b1, rd, lat, ga, ge, wide);
        adr[1] = 32'h1000_0020; dat_w[1] = 32'hDEAD_BEEF; sel[1] = 4'hF; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        resp = 0;
        tick();                        // edge N
        tick();                        // edge N+1
        cyc[1] = 1'b0;                 // stb stays high: must be ignored
        for (int e = 0; e < 8; e++) begin
            tick();
            if (ack[1] || err[1]) resp++;
        end
        stb[1] = 1'b0; we[1] = 1'b0;
        total++; if (resp !== 0) begin bad++; $display("FAIL abort_resp got=%0d want=0", resp); end
        xfer(1, 32'h1000_0020, 32'h0, 4'hF, 1'b0, rd, lat, ga, ge, wide);
        total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL abort_data got=%h want=00000001", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; logic ga, ge, wide;
        xfer(2, 32'h1000_0030, 32'h0000_5555, 4'hF, 1'b1, rd, lat, ga, ge, wide);
        total++; if (lat !== 3) begin bad++; $display("FAIL rm_pre_lat got=%0d want=3", lat); end
        // Target 0 is reading so its outputs are live when reset hits.
        adr[0] = 32'h1000_0000; we[0] = 1'b0; sel[0] = 4'hF; cyc[0] = 1'b1; stb[0] = 1'b1;
        adr[2] = 32'h1000_0030; dat_w[2] = 32'h1234_5678; sel[2] = 4'hF; we[2] = 1'b1;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        tick();                        // edge N
        tick();                        // edge N+1
        cyc[0] = 1'b0; stb[0] = 1'b0;
        total++; if (ack[0] !== 1'b1 || dat_r[0] !== 32'hA5A5_0000) begin
            bad++; $display("FAIL rm_live got=%b/%h want=1/a5a50000", ack[0], dat_r[0]);
        end
        #3 reset = 1'b0;
        #1;
        total++; if (ack[0] !== 1'b0) begin bad++; $display("FAIL rm_async_ack got=%b want=0", ack[0]); end
        total++; if (dat_r[0] !== 32'h0) begin bad++; $display("FAIL rm_async_dat_r got=%h want=0", dat_r[0]); end
        total++; if (ack[2] !== 1'b0 || err[2] !== 1'b0 || dat_r[2] !== 32'h0) begin
            bad++; $display("FAIL rm_async_t2 got=%b/%b/%h want=0/0/0", ack[2], err[2], dat_r[2]);
        end
        tick(); tick(); tick();
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        #3 reset = 1'b1;
        xfer(2, 32'h1000_0030, 32'h0, 4'hF, 1'b0, rd, lat, ga, ge, wide);
        total++; if (ga !== 1'b1 || lat !== 3) begin bad++; $display("FAIL rm_idle got=%b/%0d want=1/3", ga, lat); end
        total++; if (rd !== 32'h0000_5555) begin bad++; $display("FAIL rm_word got=%h want=00005555", rd); end
        xfer(0, 32'h1000_0000, 32'h0, 4'hF, 1'b0, rd, lat, ga, ge, wide);
        total++; if (rd !== 32'hA5A5_0000) begin bad++; $display("FAIL rm_mem_kept got=%h want=a5a50000", rd); end
    endtask

    initial begin
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            adr[k] = '0; dat_w[k] = '0; sel[k] = '0; we[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
        end
        #1;
        test_reset();
        tick(); tick();
        #3 reset = 1'b1;
        tick();
        test_reset();
        test_write_readback();
        test_byte_enables();
        test_error_decode();
        test_wait_states();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
